i2c_passthru_bittx: RTL and testbench
=====================================

I2C_PASSTHRU_BITTX -- requirements
Module: i2c_passthru_bittx

Interface
REQ-001 Parameter F_REF_T_LOW, default 38: i_f_ref rising edges per timed phase (t_low, t_high, t_su_sto, t_buf, t_hd_sta); minimum 2.
REQ-002 Parameter WIDTH_F_REF_T_LOW, default 6: timer width, CEILING(LOG2(F_REF_T_LOW+1)).
REQ-003 Parameter F_REF_T_STRETCH, default 255: stretch timeout in i_f_ref edges; used only under REQ-033.
REQ-004 Parameter WIDTH_F_REF_T_STRETCH, default 8: stretch timer width.
REQ-005 i_clk  input  1  clock; one clock domain.
REQ-006 i_rstn  input  1  asynchronous active-low reset.
REQ-007 i_f_ref  input  1  timing reference, synchronous to i_clk.
REQ-008 i_start_tx  input  1  start replaying one bit.
REQ-009 i_rx_sda_init_valid, i_rx_sda_init, i_rx_sda_mid_change, i_rx_sda_final, i_rx_done  input  1 each  bit status from upstream bit receiver.
REQ-010 i_scl, i_sda  input  1 each  sampled far-side bus lines.
REQ-011 o_scl, o_sda  output  1 each  far-side drive; 0 = pull low, 1 = release.
REQ-012 o_tx_done  output  1  level, high while bit replay finished (feeds receiver i_tx_done).
REQ-013 o_violation  output  1  level, bus fault latched.

Function
REQ-014 pulse_ref = i_f_ref high and previous-cycle i_f_ref low; one timer counts down on pulse_ref, saturates at 0 (tc), reloads F_REF_T_LOW when reset by the FSM.
REQ-015 Register sda_reg holds the level driven on o_sda in every non-violation state except DONE_HIGH idle release (o_sda = sda_reg there too).
REQ-016 States: IDLE_LOW, WAIT_INIT, SETUP, RISE, HIGH, MID1, MID2, DONE_HIGH, VIOLATION; undefined encodings -> IDLE_LOW next cycle.
REQ-017 IDLE_LOW: o_scl=0, o_tx_done=1, timer reset; i_start_tx -> WAIT_INIT.
REQ-018 DONE_HIGH: o_scl=1, o_tx_done=1, timer reset; i_start_tx -> WAIT_INIT.
REQ-019 WAIT_INIT: o_scl=0, timer reset; i_rx_sda_init_valid -> sda_reg<=i_rx_sda_init, go SETUP.
REQ-020 SETUP: o_scl=0; timer tc -> RISE (guarantees t_low and t_su_dat).
REQ-021 RISE: o_scl=1; i_scl=1 -> HIGH, timer reset; no time limit unless REQ-033.
REQ-022 HIGH: o_scl=1; i_sda != sda_reg -> VIOLATION (priority); else timer tc and i_rx_sda_mid_change -> sda_reg toggled, timer reset, MID1; else timer tc and i_rx_done -> IDLE_LOW.
REQ-023 MID1: o_scl=1; on timer tc and i_rx_done: i_rx_sda_final == sda_reg -> DONE_HIGH; else sda_reg toggled, timer reset, MID2.
REQ-024 MID2: o_scl=1; timer tc -> DONE_HIGH.
REQ-025 VIOLATION: o_scl=1, o_sda=1, o_violation=1, o_tx_done=0; exited only by reset.
REQ-026 o_tx_done=0 and o_violation=0 in all states except as stated above.
REQ-027 HIGH with i_rx_done and mid_change both set at tc: mid_change wins.
REQ-028 i_start_tx ignored outside IDLE_LOW/DONE_HIGH; init_valid ignored outside WAIT_INIT.
REQ-029 All outputs decoded combinationally from state and sda_reg; state change latency 1 i_clk.

Reset
REQ-030 i_rstn low asynchronously forces state DONE_HIGH, sda_reg=1, prev i_f_ref=0, timer=F_REF_T_LOW, stretch timer cleared.
REQ-031 Reset outputs: o_scl=1, o_sda=1, o_tx_done=1, o_violation=0; reset mid-bit abandons the bit with no further bus activity.
REQ-032 Deassertion: first transition evaluated on next i_clk rising edge.

Configuration
REQ-033 Macro I2C_PASSTHRU_BITTX_STRETCH_TIMEOUT_EN defined: in RISE a second timer reloaded on RISE entry counts pulse_ref; reaching F_REF_T_STRETCH with i_scl=0 -> VIOLATION; undefined: no stretch timer, RISE waits indefinitely.

Verification
REQ-034 Data bit 0: start, init_valid init=0, i_scl follows o_scl, rx_done -> o_sda=0 whole high phase, o_scl low >= 38 pulse_ref, ends IDLE_LOW, o_tx_done=1.
REQ-035 STOP: init=0, mid_change, rx_done final=1 -> o_sda rises after 38 edges of high, DONE_HIGH with o_scl=1, o_sda=1.
REQ-036 Double change: init=1, mid_change, rx_done final=1 -> o_sda 1->0->1, each level held 38 edges, DONE_HIGH.
REQ-037 Conflict: sda_reg=1, i_sda forced 0 in HIGH -> o_violation=1 next cycle, held until reset.
REQ-038 i_scl held 0 300 edges in RISE: macro defined -> violation at edge 255; undefined -> still RISE, no violation.
REQ-039 i_rstn pulsed low in MID1 -> immediately o_scl=1, o_sda=1, o_tx_done=1, o_violation=0.

Source files
------------

// File: rtl/i2c_passthru_bittx.sv
// ---------------------------------------------------------------------------------------------
// i2c_passthru_bittx
//
// Replays one I2C bit, as reported by an upstream bit receiver, onto the far-side bus. SCL is
// driven low for t_low, released and awaited (clock stretching), held high for t_high, and the
// SDA level is changed in the high phase when the received bit contained a START/STOP condition.
// A mismatch between the driven and the observed SDA while SCL is high latches a bus violation.
//
// Optional feature: define I2C_PASSTHRU_BITTX_STRETCH_TIMEOUT_EN to bound how long the far side
// may hold SCL low after release (F_REF_T_STRETCH reference edges). Undefined: no bound.
//
// Ports
//   i_clk, i_rstn             clock, asynchronous active-low reset
//   i_f_ref                   timing reference (rising edges are counted)
//   i_start_tx                start replaying one bit
//   i_rx_sda_init_valid/_init initial SDA level of the received bit
//   i_rx_sda_mid_change       SDA changed while SCL was high
//   i_rx_sda_final            final SDA level of the received bit
//   i_rx_done                 received bit complete
//   i_scl, i_sda              sampled far-side bus lines
//   o_scl, o_sda              far-side drive (0 = pull low, 1 = release)
//   o_tx_done                 high while bit replay is finished
//   o_violation               bus fault latched
// ---------------------------------------------------------------------------------------------
module i2c_passthru_bittx #(
    parameter int unsigned F_REF_T_LOW           = 38,
    parameter int unsigned WIDTH_F_REF_T_LOW     = 6,
    parameter int unsigned F_REF_T_STRETCH       = 255,
    parameter int unsigned WIDTH_F_REF_T_STRETCH = 8
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_f_ref,
    input  logic i_start_tx,
    input  logic i_rx_sda_init_valid,
    input  logic i_rx_sda_init,
    input  logic i_rx_sda_mid_change,
    input  logic i_rx_sda_final,
    input  logic i_rx_done,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl,
    output logic o_sda,
    output logic o_tx_done,
    output logic o_violation
);

    typedef enum logic [3:0] {
        StIdleLow   = 4'd0,
        StWaitInit  = 4'd1,
        StSetup     = 4'd2,
        StRise      = 4'd3,
        StHigh      = 4'd4,
        StMid1      = 4'd5,
        StMid2      = 4'd6,
        StDoneHigh  = 4'd7,
        StViolation = 4'd8
    } state_e;

    localparam logic [WIDTH_F_REF_T_LOW-1:0] TimerLoad = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);

    state_e                         state_q, state_d;
    logic                           sda_q, sda_d;
    logic                           f_ref_q;
    logic [WIDTH_F_REF_T_LOW-1:0]   timer_q, timer_d;
    logic                           timer_rst;
    logic                           pulse_ref;
    logic                           tc;
    logic                           stretch_hit;

    assign pulse_ref = i_f_ref & ~f_ref_q;
    assign tc        = (timer_q == '0);

    // Phase timer: counts reference edges down and parks at zero until reloaded.
    always_comb begin
        timer_d = timer_q;
        if (timer_rst) begin
            timer_d = TimerLoad;
        end else if (pulse_ref && !tc) begin
            timer_d = timer_q - WIDTH_F_REF_T_LOW'(1);
        end
    end

`ifdef I2C_PASSTHRU_BITTX_STRETCH_TIMEOUT_EN
    localparam logic [WIDTH_F_REF_T_STRETCH-1:0] StretchMax =
        WIDTH_F_REF_T_STRETCH'(F_REF_T_STRETCH);

    logic [WIDTH_F_REF_T_STRETCH-1:0] stretch_q, stretch_d;

    // Held at zero outside RISE, so it restarts from zero on every RISE entry.
    always_comb begin
        stretch_d = stretch_q;
        if (state_q != StRise) begin
            stretch_d = '0;
        end else if (pulse_ref && (stretch_q != StretchMax)) begin
            stretch_d = stretch_q + WIDTH_F_REF_T_STRETCH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stretch_q <= '0;
        end else begin
            stretch_q <= stretch_d;
        end
    end

    assign stretch_hit = (stretch_q == StretchMax);
`else
    assign stretch_hit = 1'b0;
`endif

    // State, SDA level and timer registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= StDoneHigh;
            sda_q   <= 1'b1;
            f_ref_q <= 1'b0;
            timer_q <= TimerLoad;
        end else begin
            state_q <= state_d;
            sda_q   <= sda_d;
            f_ref_q <= i_f_ref;
            timer_q <= timer_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        sda_d     = sda_q;
        timer_rst = 1'b0;
        case (state_q)
            StIdleLow, StDoneHigh: begin
                timer_rst = 1'b1;
                if (i_start_tx) state_d = StWaitInit;
            end
            StWaitInit: begin
                timer_rst = 1'b1;
                if (i_rx_sda_init_valid) begin
                    sda_d   = i_rx_sda_init;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (tc) state_d = StRise;
            end
            StRise: begin
                if (i_scl) begin
                    timer_rst = 1'b1;
                    state_d   = StHigh;
                end else if (stretch_hit) begin
                    state_d = StViolation;
                end
            end
            StHigh: begin
                // A foreign driver on SDA takes precedence over any timed action.
                if (i_sda != sda_q) begin
                    state_d = StViolation;
                end else if (tc && i_rx_sda_mid_change) begin
                    sda_d     = ~sda_q;
                    timer_rst = 1'b1;
                    state_d   = StMid1;
                end else if (tc && i_rx_done) begin
                    state_d = StIdleLow;
                end
            end
            StMid1: begin
                if (tc && i_rx_done) begin
                    if (i_rx_sda_final == sda_q) begin
                        state_d = StDoneHigh;
                    end else begin
                        sda_d     = ~sda_q;
                        timer_rst = 1'b1;
                        state_d   = StMid2;
                    end
                end
            end
            StMid2: begin
                if (tc) state_d = StDoneHigh;
            end
            StViolation: begin
                state_d = StViolation;
            end
            default: begin
                state_d = StIdleLow;
            end
        endcase
    end

    // Output decode.
    always_comb begin
        o_scl       = 1'b1;
        o_sda       = sda_q;
        o_tx_done   = 1'b0;
        o_violation = 1'b0;
        case (state_q)
            StIdleLow: begin
                o_scl     = 1'b0;
                o_tx_done = 1'b1;
            end
            StDoneHigh: begin
                o_tx_done = 1'b1;
            end
            StWaitInit, StSetup: begin
                o_scl = 1'b0;
            end
            StRise, StHigh, StMid1, StMid2: begin
                o_scl = 1'b1;
            end
            StViolation: begin
                o_sda       = 1'b1;
                o_violation = 1'b1;
            end
            default: begin
                o_sda = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_i2c_passthru_bittx.sv
// Scoreboard bench: each expected output change {scl, sda, tx_done, violation} is queued with the
// allowed range of reference edges since the previous change; the monitor compares on change.
module tb_i2c_passthru_bittx;

    logic i_clk = 1'b0;
    logic i_rstn = 1'b1;
    logic i_f_ref = 1'b0;
    logic i_start_tx = 1'b0;
    logic rx_init_valid = 1'b0;
    logic rx_init = 1'b0;
    logic rx_mid = 1'b0;
    logic rx_final = 1'b0;
    logic rx_done = 1'b0;
    logic scl_force0 = 1'b0;
    logic sda_force0 = 1'b0;
    logic bus_scl, bus_sda;
    logic o_scl, o_sda, o_tx_done, o_violation;

    assign bus_scl = scl_force0 ? 1'b0 : o_scl;
    assign bus_sda = sda_force0 ? 1'b0 : o_sda;

    i2c_passthru_bittx dut (
        .i_clk               (i_clk),
        .i_rstn              (i_rstn),
        .i_f_ref             (i_f_ref),
        .i_start_tx          (i_start_tx),
        .i_rx_sda_init_valid (rx_init_valid),
        .i_rx_sda_init       (rx_init),
        .i_rx_sda_mid_change (rx_mid),
        .i_rx_sda_final      (rx_final),
        .i_rx_done           (rx_done),
        .i_scl               (bus_scl),
        .i_sda               (bus_sda),
        .o_scl               (o_scl),
        .o_sda               (o_sda),
        .o_tx_done           (o_tx_done),
        .o_violation         (o_violation)
    );

    typedef struct {
        logic [3:0] out;
        int         min_p;
        int         max_p;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    initial forever #5 i_clk = ~i_clk;

    // Reference toggles every clock: one rising edge per two clocks.
    initial forever begin
        @(posedge i_clk);
        #1 i_f_ref = ~i_f_ref;
    end

    // Monitor: counts reference edges and checks every output change against the queue.
    initial begin
        logic [3:0] last;
        logic [3:0] cur;
        logic       prev_f;
        int         pulses;
        exp_t       e;
        last   = 'x;
        prev_f = 1'b0;
        pulses = 0;
        forever begin
            @(posedge i_clk);
            if (i_f_ref && !prev_f) pulses++;
            prev_f = i_f_ref;
            @(negedge i_clk);
            cur = {o_scl, o_sda, o_tx_done, o_violation};
            if (cur !== last) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected: outputs %b after %0d pulses, none expected",
                             cur, pulses);
                end else begin
                    e = q.pop_front();
                    if (cur === e.out && pulses >= e.min_p && pulses <= e.max_p) begin
                        passes++;
                    end else begin
                        $display("FAIL %s: got %b after %0d pulses, want %b after %0d..%0d",
                                 e.name, cur, pulses, e.out, e.min_p, e.max_p);
                    end
                end
                last   = cur;
                pulses = 0;
            end
        end
    end

    task automatic push(input logic [3:0] out, input int mn, input int mx, input string nm);
        exp_t e;
        e.out   = out;
        e.min_p = mn;
        e.max_p = mx;
        e.name  = nm;
        q.push_back(e);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            $display("FAIL %s: timeout, %0d expected events pending, want 0", nm, q.size());
            q.delete();
        end
    endtask

    task automatic start_bit(input logic init, input logic mid, input logic dn, input logic fin);
        rx_init_valid = 1'b1;
        rx_init       = init;
        rx_mid        = mid;
        rx_done       = dn;
        rx_final      = fin;
        @(posedge i_clk);
        #1 i_start_tx = 1'b1;
        @(posedge i_clk);
        #1 i_start_tx = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge i_clk);
        #2 i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_rstn = 1'b1;
    endtask

    task automatic wait_pulses(input int n);
        repeat (2 * n) @(posedge i_clk);
    endtask

    initial begin
        // Reset state: DONE_HIGH, bus released.
        push(4'b1110, 0, 100000, "reset");
        #1 i_rstn = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rstn = 1'b1;
        drain("reset");

        // Data bit 0.
        push(4'b0100, 0, 100000, "bit0 start");
        push(4'b0000, 0, 1, "bit0 init");
        push(4'b1000, 38, 40, "bit0 scl rise");
        push(4'b0010, 38, 40, "bit0 idle low");
        start_bit(1'b0, 1'b0, 1'b1, 1'b0);
        drain("bit0");

        // STOP: mid_change wins over rx_done in HIGH.
        push(4'b0000, 0, 100000, "stop start");
        push(4'b1000, 38, 40, "stop scl rise");
        push(4'b1100, 38, 40, "stop sda rise");
        push(4'b1110, 38, 40, "stop done high");
        start_bit(1'b0, 1'b1, 1'b1, 1'b1);
        drain("stop");

        // Double change: 1 -> 0 -> 1.
        push(4'b0100, 0, 100000, "dbl start");
        push(4'b1100, 38, 40, "dbl scl rise");
        push(4'b1000, 38, 40, "dbl first change");
        push(4'b1100, 38, 40, "dbl second change");
        push(4'b1110, 38, 40, "dbl done high");
        start_bit(1'b1, 1'b1, 1'b1, 1'b1);
        drain("dbl");

        // SDA conflict in HIGH latches a violation until reset.
        sda_force0 = 1'b1;
        push(4'b0100, 0, 100000, "conf start");
        push(4'b1100, 38, 40, "conf scl rise");
        push(4'b1101, 0, 2, "conf violation");
        start_bit(1'b1, 1'b0, 1'b1, 1'b0);
        drain("conf");
        repeat (200) @(negedge i_clk);
        push(4'b1110, 0, 100000, "conf reset");
        pulse_reset();
        sda_force0 = 1'b0;
        drain("conf reset");

        // Reset while in MID1 abandons the bit.
        push(4'b0100, 0, 100000, "mid1 start");
        push(4'b0000, 0, 1, "mid1 init");
        push(4'b1000, 38, 40, "mid1 scl rise");
        push(4'b1100, 38, 40, "mid1 entry");
        start_bit(1'b0, 1'b1, 1'b0, 1'b0);
        drain("mid1");
        wait_pulses(10);
        push(4'b1110, 0, 100000, "mid1 reset");
        pulse_reset();
        drain("mid1 reset");
        repeat (100) @(negedge i_clk);

        // Far side holds SCL low for 300 reference edges in RISE.
        scl_force0 = 1'b1;
        push(4'b0100, 0, 100000, "stretch start");
        push(4'b0000, 0, 1, "stretch init");
        push(4'b1000, 38, 40, "stretch scl rise");
        start_bit(1'b0, 1'b0, 1'b1, 1'b0);
        drain("stretch rise");
`ifdef I2C_PASSTHRU_BITTX_STRETCH_TIMEOUT_EN
        push(4'b1101, 255, 257, "stretch timeout");
        wait_pulses(300);
        #1 scl_force0 = 1'b0;
        drain("stretch timeout");
        push(4'b1110, 0, 100000, "stretch reset");
        pulse_reset();
        drain("stretch reset");
`else
        push(4'b0010, 338, 343, "stretch wait");
        wait_pulses(300);
        #1 scl_force0 = 1'b0;
        drain("stretch wait");
`endif
        repeat (20) @(negedge i_clk);
        drain("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
